sm4_cbc_ctrl: RTL

Block-mode controller for the iterative SM4 encryption core. It accepts a stream of 128-bit plaintext blocks over a valid/ready handshake and applies ECB or CBC chaining. For each block it pulses the core's reset, runs the core until its done flag, and returns ciphertext over a second valid/ready handshake. It sits between the system data path and a single SM4 core instance, and owns that core's reset, enable, data and key inputs.

---
 rtl/sm4_cbc_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sm4_cbc_ctrl.sv
// ECB/CBC block-mode controller for one iterative SM4 core: pulses the core reset per block,
// runs it to done (or a cycle timeout) and returns ciphertext over a valid/ready handshake.
module sm4_cbc_ctrl #(
    parameter int TIMEOUT = 48
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         START,
    input  logic         MODE_CBC,
    input  logic [127:0] IV,
    input  logic [127:0] KEY,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [127:0] IN_DATA,
    input  logic         IN_LAST,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [127:0] OUT_DATA,
    output logic         OUT_LAST,
    output logic         CORE_RST_N,
    output logic         CORE_EN,
    output logic [127:0] CORE_DATA,
    output logic [127:0] CORE_KEY,
    input  logic [127:0] CORE_OUT,
    input  logic         CORE_DONE,
    output logic         BUSY,
    output logic         ERR
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_IN, S_CRST, S_RUN, S_OUT, S_ERR
    } state_t;

    state_t          r_state, w_next;
    logic [1:0]      r_crst_cnt;
    logic [CW-1:0]   r_run_cnt;
    logic            r_mode, r_last;
    logic [127:0]    r_chain;
    logic            r_in_ready, r_out_valid, r_out_last, r_core_rst_n, r_core_en, r_busy, r_err;
    logic [127:0]    r_out_data, r_core_data, r_core_key;
    logic            w_start, w_accept, w_done;

    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_accept = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            S_IDLE, S_ERR: begin
                if (START) begin
                    w_start = 1'b1;
                    w_next  = S_WAIT_IN;
                end
            end
            S_WAIT_IN: begin
                if (IN_VALID && r_in_ready) begin
                    w_accept = 1'b1;
                    w_next   = S_CRST;
                end
            end
            S_CRST: begin
                if (r_crst_cnt == 2'd1) w_next = S_RUN;
            end
            S_RUN: begin
                // Done has priority over a timeout landing on the same cycle.
                if (CORE_DONE) begin
                    w_done = 1'b1;
                    w_next = S_OUT;
                end else if (r_run_cnt == TO_VAL) begin
                    w_next = S_ERR;
                end
            end
            S_OUT: begin
                if (OUT_READY) w_next = r_last ? S_IDLE : S_WAIT_IN;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= S_IDLE;
            r_crst_cnt <= 2'd0;
            r_run_cnt  <= '0;
        end else begin
            r_state    <= w_next;
            r_crst_cnt <= (r_state == S_CRST) ? r_crst_cnt + 2'd1 : 2'd0;
            r_run_cnt  <= (r_state == S_RUN) ? r_run_cnt + 1'b1 : '0;
        end
    end

    // Control outputs are registered from the next state so they align with it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_core_en    <= 1'b0;
            r_core_rst_n <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_mode       <= 1'b0;
            r_last       <= 1'b0;
            r_chain      <= '0;
            r_core_key   <= '0;
            r_core_data  <= '0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
        end else begin
            r_in_ready   <= (w_next == S_WAIT_IN);
            r_out_valid  <= (w_next == S_OUT);
            r_core_en    <= (w_next == S_RUN);
            r_core_rst_n <= (w_next == S_RUN);
            r_busy       <= (w_next != S_IDLE) && (w_next != S_ERR);
            r_err        <= (w_next == S_ERR);
            if (w_start) begin
                r_core_key <= KEY;
                r_mode     <= MODE_CBC;
                r_chain    <= IV;
            end
            if (w_accept) begin
                r_core_data <= IN_DATA ^ (r_mode ? r_chain : 128'd0);
                r_last      <= IN_LAST;
            end
            if (w_done) begin
                r_out_data <= CORE_OUT;
                r_chain    <= CORE_OUT;
                r_out_last <= r_last;
            end
        end
    end

    assign IN_READY   = r_in_ready;
    assign OUT_VALID  = r_out_valid;
    assign OUT_DATA   = r_out_data;
    assign OUT_LAST   = r_out_last;
    assign CORE_RST_N = r_core_rst_n;
    assign CORE_EN    = r_core_en;
    assign CORE_DATA  = r_core_data;
    assign CORE_KEY   = r_core_key;
    assign BUSY       = r_busy;
    assign ERR        = r_err;
endmodule
